// File: rtl/inst_enc.sv
// RV32I instruction-word encoder feeding a 2-entry output FIFO.
// Optional macro INST_ENC_RANGE_CHECK_EN adds immediate range checking to out_err.
module inst_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_cnt
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0] enc_inst;
    logic        fmt_bad;
    logic        range_bad;
    logic        enc_err;

    always_comb begin
        enc_inst = 32'h0;
        fmt_bad  = 1'b0;
        case (in_fmt)
            FMT_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_inst = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    // Flag immediates a decoder could not reproduce from the encoded bits.
    always_comb begin
        range_bad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: range_bad = (in_imm[31:11] != {21{in_imm[11]}});
            FMT_B:        range_bad = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            FMT_J:        range_bad = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            FMT_U:        range_bad = (in_imm[11:0] != 12'h0);
            default:      range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign enc_err = fmt_bad | range_bad;

    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic [15:0] cnt_reg;
    logic        push;
    logic        pop;
    logic [31:0] slot_inst [2];
    logic        slot_err  [2];

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] inst_reg;
            logic        err_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    inst_reg <= 32'h0;
                    err_reg  <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    inst_reg <= enc_inst;
                    err_reg  <= enc_err;
                end
            end
            assign slot_inst[gi] = inst_reg;
            assign slot_err[gi]  = err_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            cnt_reg    <= 16'h0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                cnt_reg    <= cnt_reg + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_inst = slot_inst[rd_ptr_reg];
    assign out_err  = slot_err[rd_ptr_reg];
    assign enc_cnt  = cnt_reg;
endmodule

// File: tb/tb_inst_enc.sv
// Directed testbench for inst_enc: encodings, backpressure ordering, reset flush.
module tb_inst_enc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;
    logic rc;

    inst_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .enc_cnt(enc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // One request into an empty FIFO, checked one cycle later, then drained.
    task automatic one(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_inst, input logic exp_err);
        set_in(fmt, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        #1;
        chk({tag, "_nobypass"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, out_inst, exp_inst);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        $display("vec %s: inst=%h err=%0d", tag, out_inst, out_err);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_cnt"}, 32'(enc_cnt), 32'(exp_cnt));
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
`ifdef INST_ENC_RANGE_CHECK_EN
        rc = 1'b1;
`else
        rc = 1'b0;
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_in(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);

        // Backpressure: three back-to-back requests with out_ready low.
        set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);       // A 0x00500093
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        set_in(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000); // B 0x123452B7
        @(negedge clk);
        chk("bp_ready_after2", 32'(in_ready), 32'd0);
        chk("bp_head_a", out_inst, 32'h00500093);
        set_in(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);       // C 0x403100B3
        @(negedge clk);
        chk("bp_c_waits", 32'(in_ready), 32'd0);
        chk("bp_head_a_held", out_inst, 32'h00500093);
        out_ready = 1'b1;
        @(negedge clk);
        $display("bp out0: inst=%h", 32'h00500093);
        chk("bp_head_b", out_inst, 32'h123452B7);
        chk("bp_cnt1", 32'(enc_cnt), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_head_c", out_inst, 32'h403100B3);
        chk("bp_cnt2", 32'(enc_cnt), 32'd2);
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_cnt3", 32'(enc_cnt), 32'd3);
        chk("bp_drained", 32'(out_valid), 32'd0);
        $display("bp done: enc_cnt=%0d", enc_cnt);
        exp_cnt = 3;

        one("I_addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        one("S_sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
        one("B_neg4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        one("J_800", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h001000EF, 1'b0);
        one("R_sub", 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF, 32'h403100B3, 1'b0);
        one("U_lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        one("fmt7", 3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F, 32'h5, 32'h0, 1'b1);
        one("fmt6", 3'd6, 7'h33, 5'd4, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0, 32'h0, 1'b1);
        one("I_800", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h80000093, rc);
        one("J_801", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h801, 32'h001000EF, rc);
        one("U_low", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h000010B7, rc);

        // Reset with two entries buffered and a handshake present in the reset cycle.
        set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_out_inst", out_inst, 32'd0);
        $display("rst flush: out_valid=%0d enc_cnt=%0d", out_valid, enc_cnt);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst2_still_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
